// File: rtl/ctrl_regs_pkg.sv
// rtl/ctrl_regs_pkg.sv - shared encodings, response codes and register indices for the control register bank
package ctrl_regs_pkg;

   typedef enum logic [2:0] {
      WR_IDLE,
      WR_WAIT_DATA,
      WR_WAIT_ADDR,
      WR_COMMIT,
      WR_RESP
   } wr_state_t;

   typedef enum logic [1:0] {
      RD_IDLE,
      RD_FETCH,
      RD_READ
   } rd_state_t;

   localparam logic [1:0] AXI_OK     = 2'b00;
   localparam logic [1:0] AXI_SLVERR = 2'b10;

   localparam int REG_CTRL   = 0;
   localparam int REG_VIEW_X = 1;
   localparam int REG_VIEW_Y = 2;
   localparam int REG_ZOOM   = 3;

   function automatic logic [31:0] merge_strb(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
      logic [31:0] res;
      res = old_val;
      for (int j = 0; j < 4; j++) begin
         if (strb[j]) res[j*8 +: 8] = new_val[j*8 +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/axi_lite_wr_channel.sv
// rtl/axi_lite_wr_channel.sv - AXI-Lite write FSM: latches AW and W in either order, issues a one-cycle commit
module axi_lite_wr_channel
   import ctrl_regs_pkg::*;
#(
   parameter int REG_FILE_SIZE       = 8,
   parameter int NUM_RO_REGS         = 2,
   parameter int AXI_LITE_ADDR_WIDTH = 8
) (
   input  logic                                 aclk,
   input  logic                                 aresetn,
   input  logic [AXI_LITE_ADDR_WIDTH-1:0]       awaddr,
   input  logic                                 awvalid,
   output logic                                 awready,
   input  logic [31:0]                          wdata,
   input  logic [3:0]                           wstrb,
   input  logic                                 wvalid,
   output logic                                 wready,
   output logic [1:0]                           bresp,
   output logic                                 bvalid,
   input  logic                                 bready,
   output logic                                 commit,
   output logic [$clog2(REG_FILE_SIZE)-1:0]     idx,
   output logic [31:0]                          data,
   output logic [3:0]                           strb,
   output logic                                 err
);

   localparam int IDX_W  = $clog2(REG_FILE_SIZE);
   localparam int NUM_RW = REG_FILE_SIZE - NUM_RO_REGS;
   localparam logic [AXI_LITE_ADDR_WIDTH-1:0] WORD_LIMIT = AXI_LITE_ADDR_WIDTH'(REG_FILE_SIZE);
   localparam logic [IDX_W-1:0]               FIRST_RO   = IDX_W'(NUM_RW);

   wr_state_t                     state, state_nxt;
   logic [AXI_LITE_ADDR_WIDTH-1:0] addr_q;
   logic [31:0]                   data_q;
   logic [3:0]                    strb_q;
   logic [1:0]                    bresp_q;
   logic                          aw_hs, w_hs;

   assign awready = aresetn && (state == WR_IDLE || state == WR_WAIT_ADDR);
   assign wready  = aresetn && (state == WR_IDLE || state == WR_WAIT_DATA);
   assign aw_hs   = awvalid && awready;
   assign w_hs    = wvalid && wready;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) state <= WR_IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         WR_IDLE: begin
            if (aw_hs && w_hs) state_nxt = WR_COMMIT;
            else if (aw_hs)    state_nxt = WR_WAIT_DATA;
            else if (w_hs)     state_nxt = WR_WAIT_ADDR;
         end
         WR_WAIT_DATA: if (w_hs)   state_nxt = WR_COMMIT;
         WR_WAIT_ADDR: if (aw_hs)  state_nxt = WR_COMMIT;
         WR_COMMIT:                state_nxt = WR_RESP;
         WR_RESP:      if (bready) state_nxt = WR_IDLE;
         default:                  state_nxt = WR_IDLE;
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         addr_q  <= '0;
         data_q  <= '0;
         strb_q  <= '0;
         bresp_q <= AXI_OK;
      end else begin
         if (aw_hs) addr_q <= awaddr;
         if (w_hs) begin
            data_q <= wdata;
            strb_q <= wstrb;
         end
         if (commit) bresp_q <= err ? AXI_SLVERR : AXI_OK;
      end
   end

   // The full upper address is compared so aliases above the bank are rejected
   assign idx    = addr_q[IDX_W+1:2];
   assign err    = ((addr_q >> 2) >= WORD_LIMIT) || (idx >= FIRST_RO);
   assign commit = (state == WR_COMMIT);
   assign data   = data_q;
   assign strb   = strb_q;
   assign bvalid = (state == WR_RESP);
   assign bresp  = bresp_q;

endmodule

// File: rtl/axi_lite_ctrl_regs.sv
// rtl/axi_lite_ctrl_regs.sv - AXI-Lite control register bank with RO status words; optional SHADOW_UPDATE_EN frame shadow
module axi_lite_ctrl_regs
   import ctrl_regs_pkg::*;
#(
   parameter int REG_FILE_SIZE       = 8,
   parameter int NUM_RO_REGS         = 2,
   parameter int AXI_LITE_ADDR_WIDTH = 8
) (
   input  logic                                          aclk,
   input  logic                                          aresetn,
   input  logic [AXI_LITE_ADDR_WIDTH-1:0]                s_axi_lite_awaddr,
   input  logic                                          s_axi_lite_awvalid,
   output logic                                          s_axi_lite_awready,
   input  logic [31:0]                                   s_axi_lite_wdata,
   input  logic [3:0]                                    s_axi_lite_wstrb,
   input  logic                                          s_axi_lite_wvalid,
   output logic                                          s_axi_lite_wready,
   output logic [1:0]                                    s_axi_lite_bresp,
   output logic                                          s_axi_lite_bvalid,
   input  logic                                          s_axi_lite_bready,
   input  logic [AXI_LITE_ADDR_WIDTH-1:0]                s_axi_lite_araddr,
   input  logic                                          s_axi_lite_arvalid,
   output logic                                          s_axi_lite_arready,
   output logic [31:0]                                   s_axi_lite_rdata,
   output logic [1:0]                                    s_axi_lite_rresp,
   output logic                                          s_axi_lite_rvalid,
   input  logic                                          s_axi_lite_rready,
   input  logic [NUM_RO_REGS*32-1:0]                     status_in,
   output logic [(REG_FILE_SIZE-NUM_RO_REGS)*32-1:0]     regs_out,
   output logic [REG_FILE_SIZE-NUM_RO_REGS-1:0]          wr_pulse,
   input  logic                                          frame_start
);

   localparam int IDX_W  = $clog2(REG_FILE_SIZE);
   localparam int NUM_RW = REG_FILE_SIZE - NUM_RO_REGS;
   localparam logic [AXI_LITE_ADDR_WIDTH-1:0] WORD_LIMIT = AXI_LITE_ADDR_WIDTH'(REG_FILE_SIZE);

   logic              wr_commit, wr_err;
   logic [IDX_W-1:0]  wr_idx;
   logic [31:0]       wr_data;
   logic [3:0]        wr_strb;
   logic [31:0]       regs_q [NUM_RW];

   axi_lite_wr_channel #(
      .REG_FILE_SIZE       (REG_FILE_SIZE),
      .NUM_RO_REGS         (NUM_RO_REGS),
      .AXI_LITE_ADDR_WIDTH (AXI_LITE_ADDR_WIDTH)
   ) u_wr_channel (
      .aclk    (aclk),
      .aresetn (aresetn),
      .awaddr  (s_axi_lite_awaddr),
      .awvalid (s_axi_lite_awvalid),
      .awready (s_axi_lite_awready),
      .wdata   (s_axi_lite_wdata),
      .wstrb   (s_axi_lite_wstrb),
      .wvalid  (s_axi_lite_wvalid),
      .wready  (s_axi_lite_wready),
      .bresp   (s_axi_lite_bresp),
      .bvalid  (s_axi_lite_bvalid),
      .bready  (s_axi_lite_bready),
      .commit  (wr_commit),
      .idx     (wr_idx),
      .data    (wr_data),
      .strb    (wr_strb),
      .err     (wr_err)
   );

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         for (int i = 0; i < NUM_RW; i++) regs_q[i] <= '0;
         wr_pulse <= '0;
      end else begin
         wr_pulse <= '0;
         if (wr_commit && !wr_err) begin
            for (int i = 0; i < NUM_RW; i++) begin
               if (wr_idx == IDX_W'(i)) begin
                  regs_q[i]   <= merge_strb(regs_q[i], wr_data, wr_strb);
                  wr_pulse[i] <= |wr_strb;
               end
            end
         end
      end
   end

   rd_state_t        rd_state, rd_state_nxt;
   logic [IDX_W-1:0] ar_idx;
   logic             ar_oor;
   logic [31:0]      rd_val;

   assign s_axi_lite_arready = aresetn && (rd_state == RD_IDLE);
   assign s_axi_lite_rvalid  = (rd_state == RD_READ);

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) rd_state <= RD_IDLE;
      else          rd_state <= rd_state_nxt;
   end

   always_comb begin
      rd_state_nxt = rd_state;
      case (rd_state)
         RD_IDLE:  if (s_axi_lite_arvalid) rd_state_nxt = RD_FETCH;
         RD_FETCH:                         rd_state_nxt = RD_READ;
         RD_READ:  if (s_axi_lite_rready)  rd_state_nxt = RD_IDLE;
         default:                          rd_state_nxt = RD_IDLE;
      endcase
   end

   always_comb begin
      rd_val = '0;
      for (int i = 0; i < NUM_RW; i++) begin
         if (ar_idx == IDX_W'(i)) rd_val = regs_q[i];
      end
      for (int k = 0; k < NUM_RO_REGS; k++) begin
         if (ar_idx == IDX_W'(NUM_RW + k)) rd_val = status_in[k*32 +: 32];
      end
   end

   // rdata is sampled from the pre-commit bank, so a same-cycle write is not observed
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         ar_idx           <= '0;
         ar_oor           <= 1'b0;
         s_axi_lite_rdata <= '0;
         s_axi_lite_rresp <= AXI_OK;
      end else begin
         if (s_axi_lite_arvalid && s_axi_lite_arready) begin
            ar_idx <= s_axi_lite_araddr[IDX_W+1:2];
            ar_oor <= (s_axi_lite_araddr >> 2) >= WORD_LIMIT;
         end
         if (rd_state == RD_FETCH) begin
            s_axi_lite_rdata <= ar_oor ? 32'h0 : rd_val;
            s_axi_lite_rresp <= ar_oor ? AXI_SLVERR : AXI_OK;
         end
      end
   end

`ifdef SHADOW_UPDATE_EN
   logic [31:0] shadow_q [NUM_RW];

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         for (int i = 0; i < NUM_RW; i++) shadow_q[i] <= '0;
      end else if (frame_start) begin
         for (int i = 0; i < NUM_RW; i++) shadow_q[i] <= regs_q[i];
      end
   end

   for (genvar i = 0; i < NUM_RW; i++) begin : g_out
      assign regs_out[i*32 +: 32] = shadow_q[i];
   end
`else
   logic unused_frame_start;
   assign unused_frame_start = frame_start;

   for (genvar i = 0; i < NUM_RW; i++) begin : g_out
      assign regs_out[i*32 +: 32] = regs_q[i];
   end
`endif

endmodule

// File: tb/tb_axi_lite_ctrl_regs.sv
// tb/tb_axi_lite_ctrl_regs.sv - directed bench for axi_lite_ctrl_regs, shadow scenario under SHADOW_UPDATE_EN
module tb_axi_lite_ctrl_regs;
   import ctrl_regs_pkg::*;

   localparam int NRW = 6;
   localparam logic [31:0] STAT0 = 32'h5A5A_0000;
   localparam logic [31:0] STAT1 = 32'hCAFE_0001;

   logic          aclk = 1'b0;
   logic          aresetn = 1'b0;
   logic [7:0]    awaddr = '0, araddr = '0;
   logic          awvalid = 0, wvalid = 0, bready = 1, arvalid = 0, rready = 1, frame_start = 0;
   logic          awready, wready, bvalid, arready, rvalid;
   logic [31:0]   wdata = '0, rdata;
   logic [3:0]    wstrb = '0;
   logic [1:0]    bresp, rresp;
   logic [63:0]   status_in;
   logic [NRW*32-1:0] regs_out;
   logic [NRW-1:0]    wr_pulse;

   int checks = 0;
   int failures = 0;

   assign status_in = {STAT1, STAT0};

   axi_lite_ctrl_regs dut (
      .aclk(aclk), .aresetn(aresetn),
      .s_axi_lite_awaddr(awaddr), .s_axi_lite_awvalid(awvalid), .s_axi_lite_awready(awready),
      .s_axi_lite_wdata(wdata), .s_axi_lite_wstrb(wstrb), .s_axi_lite_wvalid(wvalid), .s_axi_lite_wready(wready),
      .s_axi_lite_bresp(bresp), .s_axi_lite_bvalid(bvalid), .s_axi_lite_bready(bready),
      .s_axi_lite_araddr(araddr), .s_axi_lite_arvalid(arvalid), .s_axi_lite_arready(arready),
      .s_axi_lite_rdata(rdata), .s_axi_lite_rresp(rresp), .s_axi_lite_rvalid(rvalid), .s_axi_lite_rready(rready),
      .status_in(status_in), .regs_out(regs_out), .wr_pulse(wr_pulse), .frame_start(frame_start)
   );

   always #5 aclk = ~aclk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   function automatic logic [31:0] reg_word(input int i);
      return regs_out[i*32 +: 32];
   endfunction

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic do_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           output logic [1:0] resp, output logic [NRW-1:0] pulses, output bit ok);
      awaddr = addr; awvalid = 1; wdata = data; wstrb = strb; wvalid = 1;
      tick();
      awvalid = 0; wvalid = 0;
      ok = 0; pulses = '0; resp = 2'b11;
      for (int c = 0; c < 10 && !ok; c++) begin
         tick();
         pulses |= wr_pulse;
         if (bvalid) begin ok = 1; resp = bresp; end
      end
      tick();
   endtask

   task automatic do_read(input logic [7:0] addr, output logic [31:0] data, output logic [1:0] resp,
                          output bit ok);
      araddr = addr; arvalid = 1;
      tick();
      arvalid = 0;
      ok = 0; data = 32'hXXXX_XXXX; resp = 2'b11;
      for (int c = 0; c < 10 && !ok; c++) begin
         tick();
         if (rvalid) begin ok = 1; data = rdata; resp = rresp; end
      end
      tick();
   endtask

   task automatic test_reset();
      #12;
      checks++;
      if ({awready, wready, arready} !== 3'b000) begin
         failures++; $display("FAIL reset_ready: got %b want 000", {awready, wready, arready});
      end
      checks++;
      if ({bvalid, rvalid, bresp, rresp} !== 6'b0) begin
         failures++; $display("FAIL reset_resp: got %b want 000000", {bvalid, rvalid, bresp, rresp});
      end
      checks++;
      if (regs_out !== '0 || wr_pulse !== '0 || rdata !== '0) begin
         failures++; $display("FAIL reset_regs: regs_out=%h wr_pulse=%b rdata=%h want zeros", regs_out, wr_pulse, rdata);
      end
      aresetn = 1;
      tick();
      checks++;
      if ({awready, wready, arready} !== 3'b111) begin
         failures++; $display("FAIL release_ready: got %b want 111", {awready, wready, arready});
      end
   endtask

   task automatic test_basic_write();
      awaddr = 8'(REG_VIEW_X * 4); awvalid = 1; wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1;
      tick();
      awvalid = 0; wvalid = 0;
      checks++;
      if (bvalid !== 1'b0 || reg_word(REG_VIEW_X) !== 32'h0) begin
         failures++; $display("FAIL wr_early: bvalid=%b reg1=%h want 0/0", bvalid, reg_word(REG_VIEW_X));
      end
      tick();
      checks++;
      if (bvalid !== 1'b1 || bresp !== AXI_OK) begin
         failures++; $display("FAIL wr_bresp: bvalid=%b bresp=%b want 1/00", bvalid, bresp);
      end
      checks++;
      if (reg_word(REG_VIEW_X) !== 32'hDEADBEEF) begin
         failures++; $display("FAIL wr_value: got %h want deadbeef", reg_word(REG_VIEW_X));
      end
      checks++;
      if (wr_pulse !== 6'b000010) begin
         failures++; $display("FAIL wr_pulse_on: got %b want 000010", wr_pulse);
      end
      tick();
      checks++;
      if (wr_pulse !== 6'b0 || bvalid !== 1'b0) begin
         failures++; $display("FAIL wr_pulse_off: wr_pulse=%b bvalid=%b want 0/0", wr_pulse, bvalid);
      end
      araddr = 8'h04; arvalid = 1;
      tick();
      arvalid = 0;
      checks++;
      if (rvalid !== 1'b0) begin
         failures++; $display("FAIL rd_early: rvalid=%b want 0", rvalid);
      end
      tick();
      checks++;
      if (rvalid !== 1'b1 || rdata !== 32'hDEADBEEF || rresp !== AXI_OK) begin
         failures++; $display("FAIL rd_value: rvalid=%b rdata=%h rresp=%b want 1/deadbeef/00", rvalid, rdata, rresp);
      end
      tick();
   endtask

   task automatic test_w_before_aw();
      logic [1:0] resp; logic [NRW-1:0] pulses; bit ok;
      do_write(8'(REG_VIEW_Y * 4), 32'hAABBCCDD, 4'hF, resp, pulses, ok);
      wdata = 32'h11223344; wstrb = 4'b0101; wvalid = 1;
      tick();
      wvalid = 0;
      checks++;
      if (awready !== 1'b1 || wready !== 1'b0) begin
         failures++; $display("FAIL wait_addr_ready: awready=%b wready=%b want 1/0", awready, wready);
      end
      tick();
      awaddr = 8'h08; awvalid = 1;
      tick();
      awvalid = 0;
      ok = 0; resp = 2'b11;
      for (int c = 0; c < 10 && !ok; c++) begin
         tick();
         if (bvalid) begin ok = 1; resp = bresp; end
      end
      tick();
      checks++;
      if (!ok || resp !== AXI_OK || reg_word(REG_VIEW_Y) !== 32'hAA22CC44) begin
         failures++; $display("FAIL strb_merge: ok=%0d bresp=%b reg2=%h want 1/00/aa22cc44", ok, resp, reg_word(REG_VIEW_Y));
      end
   endtask

   task automatic test_errors();
      logic [1:0] resp; logic [NRW-1:0] pulses; logic [31:0] data; bit ok;
      do_write(8'h18, 32'h1, 4'hF, resp, pulses, ok);
      checks++;
      if (!ok || resp !== AXI_SLVERR || pulses !== '0) begin
         failures++; $display("FAIL ro_write: ok=%0d bresp=%b pulses=%b want 1/10/0", ok, resp, pulses);
      end
      do_write(8'h40, 32'hFFFFFFFF, 4'hF, resp, pulses, ok);
      checks++;
      if (!ok || resp !== AXI_SLVERR || pulses !== '0 || reg_word(REG_CTRL) !== 32'h0) begin
         failures++; $display("FAIL oor_write: ok=%0d bresp=%b pulses=%b reg0=%h want 1/10/0/0", ok, resp, pulses, reg_word(REG_CTRL));
      end
      do_read(8'h18, data, resp, ok);
      checks++;
      if (!ok || resp !== AXI_OK || data !== STAT0) begin
         failures++; $display("FAIL ro_read0: rdata=%h rresp=%b want %h/00", data, resp, STAT0);
      end
      do_read(8'h1C, data, resp, ok);
      checks++;
      if (!ok || resp !== AXI_OK || data !== STAT1) begin
         failures++; $display("FAIL ro_read1: rdata=%h rresp=%b want %h/00", data, resp, STAT1);
      end
      do_read(8'h20, data, resp, ok);
      checks++;
      if (!ok || resp !== AXI_SLVERR || data !== 32'h0) begin
         failures++; $display("FAIL oor_read: rdata=%h rresp=%b want 0/10", data, resp);
      end
      do_write(8'(REG_ZOOM * 4), 32'h12345678, 4'hF, resp, pulses, ok);
      do_write(8'(REG_ZOOM * 4), 32'hFFFFFFFF, 4'h0, resp, pulses, ok);
      checks++;
      if (!ok || resp !== AXI_OK || pulses !== '0 || reg_word(REG_ZOOM) !== 32'h12345678) begin
         failures++; $display("FAIL zero_strb: bresp=%b pulses=%b reg3=%h want 00/0/12345678", resp, pulses, reg_word(REG_ZOOM));
      end
      do_read(8'h0E, data, resp, ok);
      checks++;
      if (!ok || resp !== AXI_OK || data !== 32'h12345678) begin
         failures++; $display("FAIL low_addr_ignored: rdata=%h rresp=%b want 12345678/00", data, resp);
      end
   endtask

   task automatic test_back_to_back();
      araddr = 8'h0C; arvalid = 1;
      awaddr = 8'h0C; awvalid = 1; wdata = 32'h87654321; wstrb = 4'hF; wvalid = 1;
      rready = 0;
      tick();
      arvalid = 0; awvalid = 0; wvalid = 0;
      tick();
      for (int c = 0; c < 5; c++) begin
         checks++;
         if (rvalid !== 1'b1 || rdata !== 32'h12345678 || rresp !== AXI_OK || arready !== 1'b0) begin
            failures++;
            $display("FAIL hold_cycle%0d: rvalid=%b rdata=%h rresp=%b arready=%b want 1/12345678/00/0", c, rvalid, rdata, rresp, arready);
         end
         tick();
      end
      rready = 1;
      tick();
      checks++;
      if (rvalid !== 1'b0 || arready !== 1'b1 || reg_word(REG_ZOOM) !== 32'h87654321) begin
         failures++; $display("FAIL hold_release: rvalid=%b arready=%b reg3=%h want 0/1/87654321", rvalid, arready, reg_word(REG_ZOOM));
      end
   endtask

   task automatic test_reset_mid();
      bit seen;
      awaddr = 8'h04; awvalid = 1;
      tick();
      awvalid = 0;
      checks++;
      if (awready !== 1'b0 || wready !== 1'b1) begin
         failures++; $display("FAIL wait_data_ready: awready=%b wready=%b want 0/1", awready, wready);
      end
      #2;
      aresetn = 0;
      #1;
      checks++;
      if (regs_out !== '0 || {awready, wready, arready} !== 3'b000) begin
         failures++; $display("FAIL mid_reset: regs_out=%h ready=%b want 0/000", regs_out, {awready, wready, arready});
      end
      @(posedge aclk);
      #2;
      aresetn = 1;
      tick();
      checks++;
      if ({awready, wready, arready} !== 3'b111) begin
         failures++; $display("FAIL mid_release_ready: got %b want 111", {awready, wready, arready});
      end
      seen = 0;
      for (int c = 0; c < 4; c++) begin
         if (bvalid) seen = 1;
         tick();
      end
      checks++;
      if (seen) begin
         failures++; $display("FAIL dropped_txn: bvalid seen=1 want 0");
      end
   endtask

`ifdef SHADOW_UPDATE_EN
   task automatic test_shadow();
      logic [1:0] resp; logic [NRW-1:0] pulses; logic [31:0] data; bit ok;
      do_write(8'h00, 32'h5, 4'hF, resp, pulses, ok);
      checks++;
      if (!ok || pulses !== 6'b000001 || reg_word(REG_CTRL) !== 32'h0) begin
         failures++; $display("FAIL shadow_hold: pulses=%b reg0=%h want 000001/0", pulses, reg_word(REG_CTRL));
      end
      frame_start = 1;
      tick();
      frame_start = 0;
      checks++;
      if (reg_word(REG_CTRL) !== 32'h5) begin
         failures++; $display("FAIL shadow_load: reg0=%h want 5", reg_word(REG_CTRL));
      end
      awaddr = 8'h00; awvalid = 1; wdata = 32'h9; wstrb = 4'hF; wvalid = 1;
      tick();
      awvalid = 0; wvalid = 0; frame_start = 1;
      tick();
      frame_start = 0;
      checks++;
      if (bvalid !== 1'b1 || wr_pulse !== 6'b000001 || reg_word(REG_CTRL) !== 32'h5) begin
         failures++; $display("FAIL shadow_coincident: bvalid=%b wr_pulse=%b reg0=%h want 1/000001/5", bvalid, wr_pulse, reg_word(REG_CTRL));
      end
      tick();
      do_read(8'h00, data, resp, ok);
      checks++;
      if (!ok || data !== 32'h9) begin
         failures++; $display("FAIL shadow_readback: rdata=%h want 9", data);
      end
      frame_start = 1;
      tick();
      frame_start = 0;
      checks++;
      if (reg_word(REG_CTRL) !== 32'h9) begin
         failures++; $display("FAIL shadow_next_frame: reg0=%h want 9", reg_word(REG_CTRL));
      end
   endtask
`else
   task automatic test_frame_ignored();
      logic [1:0] resp; logic [NRW-1:0] pulses; bit ok;
      frame_start = 1;
      tick();
      frame_start = 0;
      do_write(8'h00, 32'h7, 4'hF, resp, pulses, ok);
      checks++;
      if (!ok || reg_word(REG_CTRL) !== 32'h7) begin
         failures++; $display("FAIL direct_out: reg0=%h want 7", reg_word(REG_CTRL));
      end
   endtask
`endif

   initial begin
      test_reset();
      test_basic_write();
      test_w_before_aw();
      test_errors();
      test_back_to_back();
      test_reset_mid();
`ifdef SHADOW_UPDATE_EN
      test_shadow();
`else
      test_frame_ignored();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/axi_lite_ctrl_regs.md
Name: axi_lite_ctrl_regs

Overview:
Parametrised AXI4-Lite slave register bank. It replaces the fixed 8-entry inline register file in the pixel pipeline top level.
- Adds byte strobes, correct SLVERR decode, read-only status registers, per-register write pulses, and optional frame-synchronous shadowing.
- Feeds coefficients and control words to the coordinate generator and function evaluator.
- Reads back pipeline status.

Parameters:
REG_FILE_SIZE, 8, total 32-bit registers; power of two, at least 2.
NUM_RO_REGS, 2, read-only status registers at the top indices; 1 to REG_FILE_SIZE-1.
AXI_LITE_ADDR_WIDTH, 8, byte address width; at least clog2(REG_FILE_SIZE)+2.
Derived: NUM_RW = REG_FILE_SIZE-NUM_RO_REGS; IDX_W = clog2(REG_FILE_SIZE).

Ports:
aclk  in  1  single clock for the AXI-Lite bus and register outputs.
aresetn  in  1  asynchronous, active-low reset.
s_axi_lite_awaddr/awvalid/awready  in/in/out  AXI_LITE_ADDR_WIDTH/1/1  write address channel.
s_axi_lite_wdata/wstrb/wvalid/wready  in/in/in/out  32/4/1/1  write data channel.
s_axi_lite_bresp/bvalid/bready  out/out/in  2/1/1  write response channel.
s_axi_lite_araddr/arvalid/arready  in/in/out  AXI_LITE_ADDR_WIDTH/1/1  read address channel.
s_axi_lite_rdata/rresp/rvalid/rready  out/out/out/in  32/2/1/1  read data channel.
status_in  in  NUM_RO_REGS*32  status words; slice k appears at index NUM_RW+k.
regs_out  out  NUM_RW*32  RW register contents, flattened; slice i is index i.
wr_pulse  out  NUM_RW  one-cycle strobe per committed RW write.
frame_start  in  1  start-of-frame pulse; used only with SHADOW_UPDATE_EN.

Behaviour:
Reset (aresetn low, asynchronous):
- All RW registers and regs_out are 0.
- wr_pulse is 0; bvalid and rvalid are 0; bresp and rresp are 00; rdata is 0.
- awready, wready and arready are 0.
- Both FSMs go to IDLE; any in-flight transaction is dropped with no response.
- All three ready outputs go to 1 in the first cycle after release.

Address decode:
- word = addr >> 2; addr[1:0] is ignored.
- If word >= REG_FILE_SIZE, the access is out of range; this checks the full upper address, not a truncated index.

Write FSM (IDLE, WAIT_DATA, WAIT_ADDR, COMMIT, RESP):
- awready is high in IDLE and WAIT_ADDR; wready is high in IDLE and WAIT_DATA.
- From IDLE: AW only goes to WAIT_DATA, W only goes to WAIT_ADDR, both go to COMMIT. Address and data/strobe are latched on their handshakes.
- COMMIT lasts one cycle:
  - RW in range: byte j is updated only if wstrb[j]=1; bresp=00.
  - RO index or out of range: the write is discarded; bresp=10.
  - wstrb=0 to an RW index: no change, no wr_pulse, bresp=00.
- RESP: bvalid stays high until bready, then the FSM returns to IDLE.
- Latency from AW+W accepted in cycle N: the new value is visible in cycle N+2, wr_pulse[i] is high in cycle N+2 only, and bvalid rises in cycle N+2.

Read FSM (IDLE, FETCH, READ), independent of the write FSM:
- arready is high in IDLE; the index is latched on the handshake.
- FETCH samples the RW register, or status_in for an RO index, into rdata.
- READ: rvalid stays high until rready. rresp=00 in range; out of range gives rresp=10 with rdata=0.
- Latency: AR accepted in cycle N gives rvalid in cycle N+2.
- A FETCH in the same cycle as a COMMIT to the same index returns the pre-write value.
- rdata and rresp are held stable while rvalid=1 and rready=0.

Optional Feature:
SHADOW_UPDATE_EN
- Defined:
  - regs_out is driven from a shadow bank.
  - The shadow is loaded from the working registers on the edge where frame_start=1.
  - A COMMIT in the same cycle as frame_start is not captured; it appears at the next frame_start.
  - AXI reads return the working value; wr_pulse timing is unchanged.
  - The shadow resets to 0.
- Undefined: regs_out is the working registers; frame_start is ignored.

Decomposition:
- Package ctrl_regs_pkg holds:
  - write and read state encodings;
  - AXI_OK=2'b00 and AXI_SLVERR=2'b10;
  - named register indices for the pixel pipeline (REG_CTRL=0, REG_VIEW_X=1, REG_VIEW_Y=2, REG_ZOOM=3).
- One natural sub-module, axi_lite_wr_channel: the write FSM plus latching. It outputs commit, idx, data, strb and err.
- The top level keeps the register bank, the strobe merge, the read FSM and the shadow.

Test Plan:
1. Reset, then AW=0x04 and W=0xDEADBEEF with strb=F in the same cycle → bvalid at +2, bresp=00, regs_out[1]=0xDEADBEEF, wr_pulse=0b000010 for one cycle; a read of 0x04 returns 0xDEADBEEF.
2. W before AW (data 0x11223344, strb=0101, 3 cycles apart) to index 2 holding 0xAABBCCDD → register becomes 0xAA22CC44, bresp=00.
3. Write 0x1 to index 6 (RO) → bresp=10, no wr_pulse. Read of 0x18 returns status_in slice 0; read of 0x20 (word 8) returns rresp=10, rdata=0.
4. Read with rready held low 5 cycles → rvalid and rdata stable for 5 cycles, arready low, then one transfer. Concurrently, a write to the same index lands in the FETCH cycle → old value returned.
5. aresetn pulsed low while in WAIT_DATA → no bvalid; all registers 0; awready=1 the cycle after release.
6. With SHADOW_UPDATE_EN: write 0x5 to index 0 → regs_out[0] stays 0 until frame_start; 1 cycle later it is 0x5. A commit coincident with frame_start appears only after the next frame_start.
